memory_scan_reader: RTL

Sequencer that sits directly upstream of `memory_python`. It owns the memory's `address` and `read_enable` inputs, walks all 2**N locations in order on a `start` pulse, and captures each returned `data` word. Captured words go to a 2-entry output buffer and leave on a valid/ready stream tagged with their address. This makes the Python-generated memory contents available to downstream logic under backpressure.

---
 rtl/memory_scan_reader.sv | 74 +++++++
 1 files changed

// File: rtl/memory_scan_reader.sv
// memory_scan_reader: reads memory addresses 0..2**N-1 in order into a 2-entry FIFO and streams each word out with its address (ports: clk, rst_n, start, mem_addr/mem_read_en/mem_data, out_data/out_addr/out_last/out_valid/out_ready, busy, done)
module memory_scan_reader #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic [N-1:0] mem_addr,
    output logic         mem_read_en,
    input  logic [N-1:0] mem_data,
    output logic [N-1:0] out_data,
    output logic [N-1:0] out_addr,
    output logic         out_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;
    state_t       state;
    logic [N:0]   next_addr;
    logic [N-1:0] buf_data [2];
    logic [N-1:0] buf_addr [2];
    logic         rd_ptr, wr_ptr;
    logic [1:0]   occ;
    logic         pop, issue;
    assign out_valid = occ != 2'd0;
    assign out_data  = buf_data[rd_ptr];
    assign out_addr  = buf_addr[rd_ptr];
    assign out_last  = out_valid && &out_addr;
    assign busy      = state != IDLE;
    assign pop       = out_valid && out_ready;
    assign issue     = state == SCAN && ({1'b0, occ} + 3'(mem_read_en)) < (3'd2 + 3'(pop));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            next_addr   <= '0;
            mem_addr    <= '0;
            mem_read_en <= 1'b0;
            done        <= 1'b0;
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            occ         <= 2'd0;
            buf_data    <= '{default: '0};
            buf_addr    <= '{default: '0};
        end else begin
            mem_read_en <= issue;
            done        <= 1'b0;
            occ         <= occ + 2'(mem_read_en) - 2'(pop);
            if (issue) begin
                mem_addr  <= next_addr[N-1:0];
                next_addr <= next_addr + 1'b1;
            end
            if (mem_read_en) begin
                buf_data[wr_ptr] <= mem_data;
                buf_addr[wr_ptr] <= mem_addr;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case (state)
                IDLE: if (start && !done) begin
                    state     <= SCAN;
                    next_addr <= '0;
                end
                SCAN: if (issue && &next_addr[N-1:0]) state <= DRAIN;
                DRAIN: if (!mem_read_en && occ == {1'b0, pop}) begin
                    state <= IDLE;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
